// File: rtl/multi_digit_alu_if.sv
// ---------------------------------------------------------------------------
// multi_digit_alu_if
// Request/response bundle between the sequencer (master) and the
// digit-serial ALU (slave).
//   start_valid / start_ready : request handshake (accept = both high)
//   op, carry_in, opnd_a, opnd_b : request payload, sampled on accept
//   abort                     : cancel the operation in flight
//   busy, done                : status; done is a one-cycle pulse
//   result, carry_out, zero_out : result bundle, updated with done
//   ovf_out                   : signed overflow, only when MDALU_OVF_EN is defined
// ---------------------------------------------------------------------------
interface multi_digit_alu_if #(
  parameter int DATA_W = 4,
  parameter int DIGITS = 8
);
  localparam int OPW = DIGITS * DATA_W;

  logic           start_valid;
  logic           start_ready;
  logic [2:0]     op;
  logic           carry_in;
  logic [OPW-1:0] opnd_a;
  logic [OPW-1:0] opnd_b;
  logic           abort;
  logic           busy;
  logic           done;
  logic [OPW-1:0] result;
  logic           carry_out;
  logic           zero_out;
`ifdef MDALU_OVF_EN
  logic           ovf_out;
`endif

  modport master (
    output start_valid, op, carry_in, opnd_a, opnd_b, abort,
    input  start_ready, busy, done, result, carry_out, zero_out
`ifdef MDALU_OVF_EN
    , input ovf_out
`endif
  );

  modport slave (
    input  start_valid, op, carry_in, opnd_a, opnd_b, abort,
    output start_ready, busy, done, result, carry_out, zero_out
`ifdef MDALU_OVF_EN
    , output ovf_out
`endif
  );
endinterface

// File: rtl/multi_digit_alu.sv
// ---------------------------------------------------------------------------
// multi_digit_alu
// Digit-serial multi-nibble arithmetic unit. One DATA_W-bit digit is
// processed per clock across a DIGITS-digit operand; a running carry links
// the digits. Supports ADD, SUB, DADD, DSUB, SHL, SHR, CMP and INC.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : multi_digit_alu_if.slave (handshake, operands, results)
//
// Optional build macro:
//   MDALU_OVF_EN : adds bus.ovf_out, the two's-complement overflow flag
//                  for ADD/SUB/CMP/INC (0 for the other ops).
// ---------------------------------------------------------------------------
module multi_digit_alu #(
  parameter int DATA_W = 4,
  parameter int DIGITS = 8
) (
  input  logic clk,
  input  logic rst_n,
  multi_digit_alu_if.slave bus
);
  localparam int OPW   = DIGITS * DATA_W;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);
  // BCD correction only makes sense for 4-bit digits; otherwise the
  // decimal ops fall back to their binary equivalents.
  localparam bit IS_BCD = (DATA_W == 4);
  localparam logic [DATA_W:0]   BCD_NINE  = (DATA_W + 1)'(9);
  localparam logic [DATA_W-1:0] DIGIT_SIX = DATA_W'(6);
  localparam logic [DATA_W-1:0] DIGIT_TEN = DATA_W'(10);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_DADD = 3'd2;
  localparam logic [2:0] OP_DSUB = 3'd3;
  localparam logic [2:0] OP_SHL  = 3'd4;
  localparam logic [2:0] OP_SHR  = 3'd5;
  localparam logic [2:0] OP_CMP  = 3'd6;
  localparam logic [2:0] OP_INC  = 3'd7;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t           r_state;
  logic [2:0]       r_op;
  logic             r_carry;
  logic [OPW-1:0]   r_a;      // shifts one digit per cycle toward the digit being processed
  logic [OPW-1:0]   r_b;
  logic [OPW-1:0]   r_acc;    // result under construction, invisible until DONE
  logic [CNT_W-1:0] r_cnt;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic [OPW-1:0]   r_result;
  logic             r_carry_out;
  logic             r_zero;

  logic [DATA_W-1:0] w_a_dig;
  logic [DATA_W-1:0] w_b_dig;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W:0]   w_shl;
  logic [DATA_W:0]   w_shr;
  logic [DATA_W-1:0] w_dig;
  logic              w_c_next;
  logic [OPW-1:0]    w_acc_next;
  logic [OPW-1:0]    w_a_shift;

  // Per-digit datapath
  always_comb begin
    // SHR walks MSD first, everything else LSD first.
    w_a_dig  = (r_op == OP_SHR) ? r_a[OPW-1 -: DATA_W] : r_a[DATA_W-1:0];
    w_b_dig  = r_b[DATA_W-1:0];
    w_sum    = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {{DATA_W{1'b0}}, r_carry};
    w_diff   = {1'b0, w_a_dig} - {1'b0, w_b_dig} - {{DATA_W{1'b0}}, r_carry};
    w_shl    = {w_a_dig, r_carry};
    w_shr    = {r_carry, w_a_dig};
    w_dig    = w_sum[DATA_W-1:0];
    w_c_next = w_sum[DATA_W];
    case (r_op)
      OP_ADD, OP_INC: begin
        w_dig    = w_sum[DATA_W-1:0];
        w_c_next = w_sum[DATA_W];
      end
      OP_SUB, OP_CMP: begin
        w_dig    = w_diff[DATA_W-1:0];
        w_c_next = w_diff[DATA_W];
      end
      OP_DADD: begin
        w_dig    = w_sum[DATA_W-1:0];
        w_c_next = w_sum[DATA_W];
        if (IS_BCD && (w_sum > BCD_NINE)) begin
          // Low bits plus 6 equals (s+6) mod 16 since 16 is a multiple of the digit range.
          w_dig    = w_sum[DATA_W-1:0] + DIGIT_SIX;
          w_c_next = 1'b1;
        end
      end
      OP_DSUB: begin
        w_dig    = w_diff[DATA_W-1:0];
        w_c_next = w_diff[DATA_W];
        if (IS_BCD && w_diff[DATA_W]) begin
          w_dig = w_diff[DATA_W-1:0] + DIGIT_TEN;
        end
      end
      OP_SHL: begin
        w_dig    = w_shl[DATA_W-1:0];
        w_c_next = w_shl[DATA_W];
      end
      OP_SHR: begin
        w_dig    = w_shr[DATA_W:1];
        w_c_next = w_shr[0];
      end
      default: begin
        w_dig    = w_sum[DATA_W-1:0];
        w_c_next = w_sum[DATA_W];
      end
    endcase
    if (r_op == OP_SHR) begin
      w_acc_next = {r_acc[OPW-DATA_W-1:0], w_dig};
      w_a_shift  = r_a << DATA_W;
    end else begin
      w_acc_next = {w_dig, r_acc[OPW-1:DATA_W]};
      w_a_shift  = r_a >> DATA_W;
    end
  end

`ifdef MDALU_OVF_EN
  // Operand sign bits are captured at accept because r_a/r_b are consumed by shifting.
  logic r_sa;
  logic r_sb;
  logic r_ovf;
  logic w_ovf;

  always_comb begin
    w_ovf = 1'b0;
    case (r_op)
      OP_ADD, OP_INC: w_ovf = (r_sa == r_sb) && (w_acc_next[OPW-1] != r_sa);
      OP_SUB, OP_CMP: w_ovf = (r_sa != r_sb) && (w_acc_next[OPW-1] != r_sa);
      default:        w_ovf = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa  <= 1'b0;
      r_sb  <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && bus.start_valid) begin
        r_sa <= bus.opnd_a[OPW-1];
        r_sb <= (bus.op == OP_INC) ? 1'b0 : bus.opnd_b[OPW-1];
      end
      if (r_state == ST_RUN && !bus.abort && r_cnt == LAST_DIGIT) begin
        r_ovf <= w_ovf;
      end
    end
  end

  assign bus.ovf_out = r_ovf;
`endif

  // Control FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_op        <= 3'd0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_zero      <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start_valid) begin
            r_state <= ST_RUN;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_op    <= bus.op;
            r_a     <= bus.opnd_a;
            // INC is ADD of zero with a forced initial carry.
            r_b     <= (bus.op == OP_INC) ? '0 : bus.opnd_b;
            r_carry <= (bus.op == OP_INC) ? 1'b1 : bus.carry_in;
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_carry <= w_c_next;
            r_acc   <= w_acc_next;
            r_a     <= w_a_shift;
            r_b     <= r_b >> DATA_W;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST_DIGIT) begin
              r_state     <= ST_DONE;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_carry_out <= w_c_next;
              r_zero      <= (w_acc_next == '0);
              // CMP only reports flags; the visible result is kept.
              if (r_op != OP_CMP) begin
                r_result <= w_acc_next;
              end
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.start_ready = r_ready;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.result      = r_result;
  assign bus.carry_out   = r_carry_out;
  assign bus.zero_out    = r_zero;
endmodule

// File: tb/tb_multi_digit_alu.sv
// ---------------------------------------------------------------------------
// tb_multi_digit_alu
// Scoreboard bench for multi_digit_alu with DIGITS=4, DATA_W=4. Expected
// results come from a whole-vector / decimal-integer reference model and are
// queued when a request is driven; a monitor pops them on each done pulse.
// ---------------------------------------------------------------------------
module tb_multi_digit_alu;
  localparam int DATA_W = 4;
  localparam int DIGITS = 4;
  localparam int OPW    = DIGITS * DATA_W;
  localparam int LAT    = DIGITS + 1;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_DADD = 3'd2;
  localparam logic [2:0] OP_DSUB = 3'd3;
  localparam logic [2:0] OP_SHL  = 3'd4;
  localparam logic [2:0] OP_SHR  = 3'd5;
  localparam logic [2:0] OP_CMP  = 3'd6;
  localparam logic [2:0] OP_INC  = 3'd7;

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        cout;
    logic        zero;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multi_digit_alu_if #(.DATA_W(DATA_W), .DIGITS(DIGITS)) bus ();
  multi_digit_alu #(.DATA_W(DATA_W), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [15:0] model_prev = 16'h0000;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic string op_name(input logic [2:0] op);
    case (op)
      OP_ADD:  return "ADD";
      OP_SUB:  return "SUB";
      OP_DADD: return "DADD";
      OP_DSUB: return "DSUB";
      OP_SHL:  return "SHL";
      OP_SHR:  return "SHR";
      OP_CMP:  return "CMP";
      default: return "INC";
    endcase
  endfunction

  function automatic int bcd2int(input logic [15:0] v);
    int s = 0;
    for (int i = DIGITS - 1; i >= 0; i--) s = s * 10 + int'(v[i*4 +: 4]);
    return s;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r = '0;
    int t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] rand_bcd();
    logic [15:0] r = '0;
    for (int i = 0; i < DIGITS; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Reference model over whole vectors / decimal integers
  function automatic exp_t model(input logic [2:0] op, input logic cin,
                                 input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] prev);
    exp_t        e;
    logic [16:0] t;
    int          v;
    int          p10;
    p10 = 10 ** DIGITS;
    e = '0;
    e.op = op; e.a = a; e.b = b;
    case (op)
      OP_ADD: begin
        t = {1'b0, a} + {1'b0, b} + 17'(cin);
        e.res = t[15:0]; e.cout = t[16];
        e.ovf = (a[15] == b[15]) && (t[15] != a[15]);
      end
      OP_SUB, OP_CMP: begin
        t = {1'b0, a} - {1'b0, b} - 17'(cin);
        e.res = t[15:0]; e.cout = t[16];
        e.ovf = (a[15] != b[15]) && (t[15] != a[15]);
      end
      OP_DADD: begin
        v = bcd2int(a) + bcd2int(b) + int'(cin);
        e.cout = (v >= p10);
        if (e.cout) v = v - p10;
        e.res = int2bcd(v);
      end
      OP_DSUB: begin
        v = bcd2int(a) - bcd2int(b) - int'(cin);
        e.cout = (v < 0);
        if (e.cout) v = v + p10;
        e.res = int2bcd(v);
      end
      OP_SHL: begin
        e.res = {a[14:0], cin}; e.cout = a[15];
      end
      OP_SHR: begin
        e.res = {cin, a[15:1]}; e.cout = a[0];
      end
      default: begin
        t = {1'b0, a} + 17'd1;
        e.res = t[15:0]; e.cout = t[16];
        e.ovf = (a == 16'h7FFF);
      end
    endcase
    e.zero = (e.res == 16'h0000);
    if (op == OP_CMP) e.res = prev;
    return e;
  endfunction

  // Monitor: compare every done pulse against the scoreboard head
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", bus.done, 1'b0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("txn op=%s a=%h b=%h -> result=%h cout=%b zero=%b", op_name(e.op), e.a, e.b,
                 bus.result, bus.carry_out, bus.zero_out);
        check({op_name(e.op), "_result"}, bus.result, e.res);
        check({op_name(e.op), "_carry"}, bus.carry_out, e.cout);
        check({op_name(e.op), "_zero"}, bus.zero_out, e.zero);
`ifdef MDALU_OVF_EN
        check({op_name(e.op), "_ovf"}, bus.ovf_out, e.ovf);
`endif
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.start_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) check("ready_timeout", bus.start_ready, 1'b1);
  endtask

  task automatic drive(input logic [2:0] op, input logic cin, input logic [15:0] a, input logic [15:0] b);
    bus.op = op; bus.carry_in = cin; bus.opnd_a = a; bus.opnd_b = b;
    bus.start_valid = 1'b1;
  endtask

  task automatic do_op(input logic [2:0] op, input logic cin, input logic [15:0] a,
                       input logic [15:0] b, input bit hold_valid);
    exp_t        e;
    int          lat;
    logic [15:0] old;
    bit          stable;
    wait_ready();
    old = model_prev;
    e = model(op, cin, a, b, model_prev);
    model_prev = e.res;
    sb_q.push_back(e);
    stable = 1'b1;
    drive(op, cin, a, b);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!hold_valid) bus.start_valid = 1'b0;
      if (lat == 1) check("busy_on_accept", {bus.busy, bus.start_ready}, 2'b10);
      if (!bus.done && bus.result !== old) stable = 1'b0;
    end while (!bus.done && lat < 4 * LAT);
    bus.start_valid = 1'b0;
    check("latency", lat, LAT);
    check("hold_during_run", stable, 1'b1);
  endtask

  // Accept a request that is never expected to complete (abort / reset cases)
  task automatic start_only(input logic [2:0] op, input logic cin, input logic [15:0] a, input logic [15:0] b);
    wait_ready();
    drive(op, cin, a, b);
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, bus.start_ready, 1'b1);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_done"}, bus.done, 1'b0);
    check({tag, "_result"}, bus.result, 16'h0000);
    check({tag, "_carry"}, bus.carry_out, 1'b0);
    check({tag, "_zero"}, bus.zero_out, 1'b1);
`ifdef MDALU_OVF_EN
    check({tag, "_ovf"}, bus.ovf_out, 1'b0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rop;
    logic [15:0] ra;
    logic [15:0] rb;
    bus.start_valid = 1'b0;
    bus.op = 3'd0; bus.carry_in = 1'b0;
    bus.opnd_a = '0; bus.opnd_b = '0; bus.abort = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    do_op(OP_DADD, 1'b0, 16'h0999, 16'h0001, 1'b0);
    do_op(OP_DSUB, 1'b0, 16'h0000, 16'h0001, 1'b0);
    do_op(OP_SUB,  1'b0, 16'h0000, 16'h0001, 1'b0);
    do_op(OP_SHL,  1'b1, 16'h8001, 16'h0000, 1'b0);
    do_op(OP_SHR,  1'b0, 16'h8001, 16'h0000, 1'b0);
    do_op(OP_ADD,  1'b0, 16'h5555, 16'h0000, 1'b0);
    do_op(OP_CMP,  1'b0, 16'h1234, 16'h1234, 1'b0);
    do_op(OP_INC,  1'b1, 16'hFFFF, 16'h1234, 1'b0);
    do_op(OP_ADD,  1'b0, 16'h7FFF, 16'h0001, 1'b0);
    do_op(OP_ADD,  1'b0, 16'h0001, 16'h0001, 1'b0);
    do_op(OP_DADD, 1'b1, 16'h9999, 16'h0000, 1'b0);
    do_op(OP_SUB,  1'b0, 16'h8000, 16'h0001, 1'b0);
    do_op(OP_INC,  1'b0, 16'h7FFF, 16'h0000, 1'b0);

    // start_valid held through the whole op: only one accept
    do_op(OP_ADD, 1'b0, 16'h1357, 16'h2468, 1'b1);
    repeat (2 * LAT) @(posedge clk);
    #1;
    check("held_valid_busy", bus.busy, 1'b0);
    check("held_valid_result", bus.result, model_prev);

    // Random mix
    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      if (rop == OP_DADD || rop == OP_DSUB) begin
        ra = rand_bcd(); rb = rand_bcd();
      end else begin
        ra = 16'($urandom); rb = 16'($urandom);
      end
      do_op(rop, 1'($urandom_range(0, 1)), ra, rb, 1'b0);
    end

    // Abort in the second RUN cycle
    start_only(OP_ADD, 1'b0, 16'h1111, 16'h2222);
    @(posedge clk); #1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check("abort_ready", bus.start_ready, 1'b1);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_result", bus.result, model_prev);
    repeat (2 * LAT) @(posedge clk);
    #1;
    do_op(OP_SUB, 1'b1, 16'h4321, 16'h1111, 1'b0);

    // Asynchronous reset in the middle of RUN
    start_only(OP_SUB, 1'b1, 16'h1234, 16'h0001);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_run_reset");
    model_prev = 16'h0000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2 * LAT) @(posedge clk);
    #1;
    check("post_reset_result", bus.result, 16'h0000);
    do_op(OP_DADD, 1'b0, 16'h0456, 16'h0544, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
